id_decode_stage: RTL

// Registered RV32I instruction-decode pipeline stage between IF and EX. Accepts a fetched

---
 rtl/riscv_pkg.sv | 87 ++++++++
 rtl/rv_imm_gen.sv | 27 ++
 rtl/id_decode_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode definitions.
//   - Opcode constants for the base ISA major opcodes.
//   - Control-bundle enums (ALU op, operand A source, write-back source, memory size,
//     immediate format) and the packed ctrl_t bundle handed from ID to EX.
//   - base_alu_op(): funct3 -> ALU op shared by OP and OP-IMM.
package riscv_pkg;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    typedef enum logic [4:0] {
        AluAdd    = 5'd0,
        AluSub    = 5'd1,
        AluSll    = 5'd2,
        AluSlt    = 5'd3,
        AluSltu   = 5'd4,
        AluXor    = 5'd5,
        AluSrl    = 5'd6,
        AluSra    = 5'd7,
        AluOr     = 5'd8,
        AluAnd    = 5'd9,
        AluMul    = 5'd10,
        AluMulh   = 5'd11,
        AluMulhsu = 5'd12,
        AluMulhu  = 5'd13,
        AluDiv    = 5'd14,
        AluDivu   = 5'd15,
        AluRem    = 5'd16,
        AluRemu   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {SrcARs1 = 2'd0, SrcAPc = 2'd1, SrcAZero = 2'd2} src_a_e;
    typedef enum logic [1:0] {WbAlu = 2'd0, WbMem = 2'd1, WbPc4 = 2'd2, WbCsr = 2'd3} wb_src_e;
    typedef enum logic [1:0] {MemByte = 2'd0, MemHalf = 2'd1, MemWord = 2'd2} mem_size_e;
    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_e;

    typedef struct packed {
        alu_op_e     alu_op;
        src_a_e      src_a;
        logic        alu_src_b;
        wb_src_e     wb_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        mem_size_e   mem_size;
        logic        mem_unsigned;
        logic        branch;
        logic [2:0]  branch_type;
        logic        jump;
        logic        jalr;
        logic        csr_op;
        logic        fence;
        logic        ecall;
        logic        ebreak;
        logic        illegal;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ctrl_t;

    // funct7 alternates (SUB/SRA) are resolved by the caller.
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'd0:    op = AluAdd;
            3'd1:    op = AluSll;
            3'd2:    op = AluSlt;
            3'd3:    op = AluSltu;
            3'd4:    op = AluXor;
            3'd5:    op = AluSrl;
            3'd6:    op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational RV32I immediate generator.
//   instr_i  in  32        raw instruction word
//   fmt_i    in  imm_fmt_e immediate format chosen by the decoder
//   imm_o    out 32        sign-extended immediate (0 for ImmNone)
module rv_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_fmt_e    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            ImmI: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            ImmS: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            ImmB: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            ImmU: imm_o = {instr_i[31:12], 12'b0};
            ImmJ: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: registered RV32I decode stage with a 2-entry skid buffer.
//   clk, reset_n            clock (rising edge), async active-low reset
//   flush_i                 drop every buffered entry and the current input
//   in_valid_i/in_ready_o   instruction handshake from IF (in_ready_o is a flop output)
//   instr_i, pc_i           raw instruction word and its address
//   out_valid_o/out_ready_i bundle handshake towards EX
//   ctrl_o, pc_o            decoded control bundle and its PC
module id_decode_stage
    import riscv_pkg::*;
#(
    parameter bit          ENABLE_M   = 1'b1,
    parameter bit          ENABLE_CSR = 1'b1,
    parameter int unsigned PC_W       = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output ctrl_t           ctrl_o,
    output logic [PC_W-1:0] pc_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    ctrl_t       dec;
    ctrl_t       ctrl_dec;
    logic        illegal;
    imm_fmt_e    fmt;
    logic [31:0] imm;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    rv_imm_gen u_imm_gen (
        .instr_i (instr_i),
        .fmt_i   (fmt),
        .imm_o   (imm)
    );

    // Field decode; register fields and the immediate are attached afterwards.
    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        fmt     = ImmNone;
        unique case (opcode)
            OpcLui: begin
                fmt = ImmU; dec.src_a = SrcAZero; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
            end
            OpcAuipc: begin
                fmt = ImmU; dec.src_a = SrcAPc; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
            end
            OpcJal: begin
                fmt = ImmJ; dec.src_a = SrcAPc; dec.alu_src_b = 1'b1;
                dec.wb_src = WbPc4; dec.reg_write = 1'b1; dec.jump = 1'b1;
            end
            OpcJalr: begin
                fmt = ImmI; dec.alu_src_b = 1'b1; dec.wb_src = WbPc4; dec.reg_write = 1'b1;
                dec.jump = 1'b1; dec.jalr = 1'b1;
                illegal = (funct3 != 3'd0);
            end
            OpcBranch: begin
                fmt = ImmB; dec.branch = 1'b1;
                illegal = (funct3 inside {3'd2, 3'd3});
            end
            OpcLoad: begin
                fmt = ImmI; dec.alu_src_b = 1'b1; dec.mem_read = 1'b1; dec.wb_src = WbMem;
                dec.reg_write = 1'b1; dec.mem_size = mem_size_e'(funct3[1:0]);
                dec.mem_unsigned = funct3[2];
                illegal = !(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            end
            OpcStore: begin
                fmt = ImmS; dec.alu_src_b = 1'b1; dec.mem_write = 1'b1;
                dec.mem_size = mem_size_e'(funct3[1:0]);
                illegal = (funct3 > 3'd2);
            end
            OpcOpImm: begin
                fmt = ImmI; dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = base_alu_op(funct3);
                if (funct3 == 3'd1) begin
                    illegal = (funct7 != 7'd0);
                end else if (funct3 == 3'd5) begin
                    illegal = (funct7 != 7'd0) && (funct7 != 7'b0100000);
                    if (funct7[5]) dec.alu_op = AluSra;
                end
            end
            OpcOp: begin
                dec.reg_write = 1'b1;
                if (funct7 == 7'd0) begin
                    dec.alu_op = base_alu_op(funct3);
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    dec.alu_op = AluSub;
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    dec.alu_op = AluSra;
                end else if (funct7 == 7'b0000001 && ENABLE_M) begin
                    // M-extension ops are numbered contiguously in funct3 order.
                    dec.alu_op = alu_op_e'(5'd10 + 5'(funct3));
                end else begin
                    illegal = 1'b1;
                end
            end
            OpcMiscMem: begin
                fmt = ImmI; dec.fence = 1'b1;
            end
            OpcSystem: begin
                fmt = ImmI;
                if (funct3 == 3'd0) begin
                    if (instr_i[31:20] == 12'd0) begin
                        dec.ecall = 1'b1;
                    end else if (instr_i[31:20] == 12'd1) begin
                        dec.ebreak = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if (ENABLE_CSR && funct3 != 3'd4) begin
                    dec.csr_op = 1'b1; dec.wb_src = WbCsr; dec.reg_write = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (instr_i[1:0] != 2'b11) illegal = 1'b1;
    end

    // An illegal instruction travels as an inert bundle; EX raises the trap.
    always_comb begin
        ctrl_dec = '0;
        if (!illegal) ctrl_dec = dec;
        ctrl_dec.illegal     = illegal;
        ctrl_dec.branch_type = funct3;
        ctrl_dec.rs1         = instr_i[19:15];
        ctrl_dec.rs2         = instr_i[24:20];
        ctrl_dec.rd          = instr_i[11:7];
        ctrl_dec.imm         = imm;
        if (instr_i[11:7] == 5'd0) ctrl_dec.reg_write = 1'b0;
    end

    // Skid buffer: out_* is the head seen by EX, skid_* catches one extra entry while stalled.
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    ctrl_t           out_q, out_d, skid_q, skid_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic            in_fire, out_fire;

    assign in_ready_o  = !skid_valid_q;
    assign in_fire     = in_valid_i && in_ready_o;
    assign out_fire    = out_valid_q && out_ready_i;
    assign out_valid_o = out_valid_q;
    assign ctrl_o      = out_q;
    assign pc_o        = out_pc_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        out_pc_d     = out_pc_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            // Head slot frees up: the older skid entry goes first to keep FIFO order.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_pc_d     = skid_pc_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_d       = ctrl_dec;
                out_pc_d    = pc_i;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = ctrl_dec;
            skid_pc_d    = pc_i;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
            out_pc_q     <= '0;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_pc_q     <= out_pc_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule
